// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding and default data-memory base address
// for the 32-bit-CPU to 16-bit-SRAM controller.
package sram_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: 4-bit wait-state counter timing one SRAM half-access.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous reset, active-low
//   i_clr   - clear counter to 0 (asserted on every state entry)
//   i_tick  - advance counter by one
//   o_last  - high in the final cycle of a WAIT_CYCLES-long half-access
module sram_wait_cnt #(
    parameter int WAIT_CYCLES = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_last
);
    logic [3:0] r_cnt;
    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= 4'd0;
        else
            r_cnt <= i_clr ? 4'd0 : (i_tick ? r_cnt + 4'd1 : r_cnt);
    end
    assign o_last = (r_cnt == 4'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits 32-bit CPU loads/stores into two timed 16-bit SRAM accesses.
// Optional macro SRAM_CTRL_ERR_EN enables an address range check with err pulse.
// Ports:
//   clk, rst           - clock (rising edge), synchronous active-low reset
//   wr_en, rd_en       - MEM-stage store/load requests (level)
//   address            - CPU byte address
//   write_data         - store data
//   read_data          - load data, valid while ready=1 in DONE
//   ready              - 0 freezes the pipeline
//   err                - out-of-range pulse (0 unless SRAM_CTRL_ERR_EN)
//   sram_addr          - SRAM half-word address
//   sram_dq_out/_in    - SRAM write/read data
//   sram_dq_oe         - drive sram_dq_out onto the pad
//   sram_we_n          - SRAM write strobe, active-low
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);
    state_t      r_state, w_next;
    logic        r_op_wr;
    logic [16:0] r_waddr;
    logic [31:0] r_wdata, r_data;
    logic        w_req, w_act, w_last, w_oor;
    logic [16:0] w_waddr;

    assign w_req   = wr_en | rd_en;
    assign w_act   = (r_state == LO) || (r_state == HI);
    assign w_waddr = 17'((address - BASE_ADDR) >> 2);

`ifdef SRAM_CTRL_ERR_EN
    logic r_err;
    // waddr >= 2^17 is equivalent to a byte offset >= 2^19
    assign w_oor = (address < BASE_ADDR) || ((address - BASE_ADDR) >= 32'h0008_0000);
    always_ff @(posedge clk) begin
        if (!rst)
            r_err <= 1'b0;
        else
            r_err <= (r_state == IDLE) && w_req && w_oor;
    end
    assign err = r_err;
`else
    assign w_oor = 1'b0;
    assign err   = 1'b0;
`endif

    sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_next != r_state),
        .i_tick (w_act),
        .o_last (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = w_oor ? DONE : LO;
            LO:      if (w_last) w_next = HI;
            HI:      if (w_last) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Store data is latched so a request dropped mid-access still writes the original word
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_op_wr <= wr_en;
                r_waddr <= w_waddr;
                r_wdata <= write_data;
            end
            if (!r_op_wr && w_last && r_state == LO)
                r_data[15:0] <= sram_dq_in;
            if (!r_op_wr && w_last && r_state == HI)
                r_data[31:16] <= sram_dq_in;
        end
    end

    assign read_data   = r_data;
    assign ready       = !(w_act || (w_req && r_state != DONE));
    assign sram_addr   = w_act ? {r_waddr, r_state == HI} : 18'd0;
    assign sram_dq_out = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
    assign sram_dq_oe  = w_act && r_op_wr;
    assign sram_we_n   = !(w_act && r_op_wr && !w_last);
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl with a small SRAM model.
module tb_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;
    logic [15:0] mem [0:255];
    int          n_chk = 0;
    int          n_err = 0;

    sram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .err         (err),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe)
            mem[sram_addr[7:0]] <= sram_dq_out;
    assign sram_dq_in = mem[sram_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts an access in the current (IDLE) cycle, drops the request in LO and
    // checks every cycle through DONE and the following IDLE cycle.
    task automatic run_acc(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [17:0] base,
                           input logic [31:0] exp_rd);
        int lows = 0;
        logic w = wr;
        wr_en = wr; rd_en = rd; address = addr; write_data = wd;
        #1 chk("req_ready", 32'(ready), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin wr_en = 1'b0; rd_en = 1'b0; end
            #1;
            chk("acc_ready", 32'(ready), 32'd0);
            chk("acc_addr", 32'(sram_addr), 32'(base + ((c > 4) ? 18'd1 : 18'd0)));
            chk("acc_oe", 32'(sram_dq_oe), 32'(w));
            chk("acc_we_n", 32'(sram_we_n), (w && c != 4 && c != 8) ? 32'd0 : 32'd1);
            if (w) chk("acc_dq", 32'(sram_dq_out), 32'((c > 4) ? wd[31:16] : wd[15:0]));
            chk("acc_err", 32'(err), 32'd0);
            if (!sram_we_n) lows++;
        end
        chk("we_low_cnt", 32'(lows), w ? 32'd6 : 32'd0);
        @(negedge clk); #1;
        chk("done_ready", 32'(ready), 32'd1);
        if (!w) chk("done_rdata", read_data, exp_rd);
        @(negedge clk); #1;
        chk("idle_addr", 32'(sram_addr), 32'd0);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);

        @(negedge clk);
        run_acc(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0);
        chk("mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("mem1", 32'(mem[1]), 32'h0000DEAD);

        @(negedge clk);
        run_acc(1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF);

        @(negedge clk);
        run_acc(1'b1, 1'b1, 32'd1028, 32'h12345678, 18'd2, 32'd0);
        chk("mem2", 32'(mem[2]), 32'h00005678);
        chk("mem3", 32'(mem[3]), 32'h00001234);
        chk("rdata_hold", read_data, 32'hDEADBEEF);

        // back-to-back: request held through DONE
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1028;
        repeat (9) @(negedge clk);
        #1 chk("b2b_done_ready", 32'(ready), 32'd1);
        chk("b2b_rdata", read_data, 32'h12345678);
        @(negedge clk); #1;
        chk("b2b_idle_ready", 32'(ready), 32'd0);
        @(negedge clk); #1;
        chk("b2b_lo_addr", 32'(sram_addr), 32'd2);
        rd_en = 1'b0;
        repeat (10) @(negedge clk);
        #1 chk("b2b_end_ready", 32'(ready), 32'd1);

        // reset in the 3rd HI cycle of a write
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        #1 chk("pre_rst_addr", 32'(sram_addr), 32'd5);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_rdata", read_data, 32'd0);
        chk("mem4", 32'(mem[4]), 32'h0000F00D);
        rst = 1'b1;
        @(negedge clk);

`ifdef SRAM_CTRL_ERR_EN
        rd_en = 1'b1; address = 32'd512;
        #1 chk("oor_req_ready", 32'(ready), 32'd0);
        @(negedge clk); #1;
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_ready", 32'(ready), 32'd1);
        chk("oor_addr", 32'(sram_addr), 32'd0);
        chk("oor_rdata", read_data, 32'd0);
        rd_en = 1'b0;
        @(negedge clk); #1;
        chk("oor_err_clr", 32'(err), 32'd0);
        chk("oor_addr2", 32'(sram_addr), 32'd0);
`else
        // (512-1024)>>2 truncated to 17 bits = 0x1FF80 -> half-word 0x3FF00
        run_acc(1'b0, 1'b1, 32'd512, 32'd0, 18'h3FF00, 32'hDEADBEEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
